// File: rtl/io_uart_ctrl.sv
// io_uart_ctrl
//   Processor IO-port front end for a UART: a TX FIFO feeding an 8N1
//   serializer, and a single-byte RX holding register fed by an external
//   receiver.
//
//   Port map (IO_port_ID):
//     0x01  read: RX byte (clears rx_full)   write: push TX byte
//     0x02  read: 0xFF if RX byte present, else 0x00
//     0x03  read: 0xFF if TX FIFO full, else 0x00
//     0x04  read: {4'b0, overflow, tx_empty, tx_busy, rx_full}
//           write: bit3 = 1 clears overflow
//
//   Ports:
//     clk100           system clock, all state on rising edge
//     reset            asynchronous, active-low
//     IO_port_ID       processor IO address
//     IO_write_data    processor write byte
//     IO_write_strobe  one write per high cycle
//     IO_read_strobe   one read per high cycle
//     IO_read_data     combinational read byte (0x00 when not strobed)
//     rx_data/rx_valid received byte from external receiver
//     rx_ready         RX holding register empty
//     uart_tx          serial line, idle high
//     tx_busy          serializer active
//
//   Serializer states:
//     state    | meaning
//     ST_IDLE  | line high, pops FIFO head when non-empty
//     ST_START | start bit (low), CLKS_PER_BIT cycles
//     ST_DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
//     ST_STOP  | stop bit (high), CLKS_PER_BIT cycles
module io_uart_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TX_DEPTH     = 4
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       uart_tx,
  output logic       tx_busy
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(TX_DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;

  logic [7:0]    fifo_mem_q [TX_DEPTH];
  logic [7:0]    fifo_mem_d [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          rx_full_q, rx_full_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          overflow_q, overflow_d;

  logic fifo_full, fifo_empty;
  logic wr_data, wr_status, rd_data;
  logic push, pop;

  // Full/empty come from registered count, so a push while full is dropped
  // even if the serializer pops in the same cycle.
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);

  assign wr_data   = IO_write_strobe && (IO_port_ID == 8'h01);
  assign wr_status = IO_write_strobe && (IO_port_ID == 8'h04);
  assign rd_data   = IO_read_strobe  && (IO_port_ID == 8'h01);

  assign push = wr_data && !fifo_full;
  assign pop  = (state_q == ST_IDLE) && !fifo_empty;

  assign tx_busy  = (state_q != ST_IDLE);
  assign rx_ready = ~rx_full_q;

  always_comb begin
    case (state_q)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = shift_q[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  always_comb begin
    IO_read_data = 8'h00;
    if (IO_read_strobe) begin
      case (IO_port_ID)
        8'h01:   IO_read_data = rx_byte_q;
        8'h02:   IO_read_data = {8{rx_full_q}};
        8'h03:   IO_read_data = {8{fifo_full}};
        8'h04:   IO_read_data = {4'b0, overflow_q, fifo_empty, tx_busy, rx_full_q};
        default: IO_read_data = 8'hFF;
      endcase
    end
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = IO_write_data;
      wr_ptr_d             = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (wr_data && fifo_full) begin
      overflow_d = 1'b1;
    end else if (wr_status && IO_write_data[3]) begin
      overflow_d = 1'b0;
    end
  end

  // Capture requires rx_full = 0 and clear requires rx_full = 1, so the two
  // can never collide in one cycle.
  always_comb begin
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (rx_valid && !rx_full_q) begin
      rx_byte_d = rx_data;
      rx_full_d = 1'b1;
    end else if (rd_data && rx_full_q) begin
      rx_full_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          shift_d = fifo_mem_q[rd_ptr_q];
          baud_d  = BAUD_LAST;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          baud_d    = BAUD_LAST;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LAST;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_full_q  <= 1'b0;
      rx_byte_q  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < TX_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_full_q  <= rx_full_d;
      rx_byte_q  <= rx_byte_d;
      overflow_q <= overflow_d;
      fifo_mem_q <= fifo_mem_d;
    end
  end

endmodule

// File: tb/tb_io_uart_ctrl.sv
// Directed bench for io_uart_ctrl with CLKS_PER_BIT = 4, TX_DEPTH = 4.
module tb_io_uart_ctrl;

  logic       clk100;
  logic       reset;
  logic [7:0] IO_port_ID;
  logic [7:0] IO_write_data;
  logic       IO_write_strobe;
  logic       IO_read_strobe;
  logic [7:0] IO_read_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       uart_tx;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mon_q[$];

  io_uart_ctrl #(.CLKS_PER_BIT(4), .TX_DEPTH(4)) dut (
    .clk100          (clk100),
    .reset           (reset),
    .IO_port_ID      (IO_port_ID),
    .IO_write_data   (IO_write_data),
    .IO_write_strobe (IO_write_strobe),
    .IO_read_strobe  (IO_read_strobe),
    .IO_read_data    (IO_read_data),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .uart_tx         (uart_tx),
    .tx_busy         (tx_busy)
  );

  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

  // Serial line monitor: samples on falling edges, start-bit sample 0 is
  // the first low sample; bit i centre is sample 5 + 4*i.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk100);
      if (uart_tx === 1'b0) begin
        b = 8'h00;
        repeat (5) @(negedge clk100);
        b[0] = uart_tx;
        for (int i = 1; i < 8; i++) begin
          repeat (4) @(negedge clk100);
          b[i] = uart_tx;
        end
        repeat (4) @(negedge clk100);
        mon_q.push_back(b);
      end
    end
  end

  // All tasks are entered and return 1 time unit after a rising edge.
  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    IO_port_ID      = port;
    IO_write_data   = data;
    IO_write_strobe = 1'b1;
    @(posedge clk100); #1;
    IO_write_strobe = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] data);
    IO_port_ID     = port;
    IO_read_strobe = 1'b1;
    #2;
    data = IO_read_data;
    @(posedge clk100); #1;
    IO_read_strobe = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    checks++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got tx=%b busy=%b rdy=%b expected 1 0 1", uart_tx, tx_busy, rx_ready);
    end
    IO_port_ID = 8'h04; IO_read_strobe = 1'b1; #1;
    d = IO_read_data;
    checks++;
    if (d !== 8'h04) begin
      errors++;
      $display("FAIL reset_status_read: got %h expected 04", d);
    end
    IO_read_strobe = 1'b0; #1;
    checks++;
    if (IO_read_data !== 8'h00) begin
      errors++;
      $display("FAIL read_no_strobe: got %h expected 00", IO_read_data);
    end
    @(posedge clk100); #1;
    reset = 1'b1;
    @(posedge clk100); #1;
  endtask

  task automatic test_single_frame;
    logic [7:0] byte_v;
    logic       exp_tx, exp_busy;
    byte_v = 8'hA5;
    mon_q.delete();
    io_write(8'h01, byte_v);
    for (int c = 0; c <= 40; c++) begin
      @(posedge clk100); #1;
      if (c < 4)       exp_tx = 1'b0;
      else if (c < 36) exp_tx = byte_v[(c - 4) / 4];
      else             exp_tx = 1'b1;
      exp_busy = (c < 40);
      checks++;
      if (uart_tx !== exp_tx || tx_busy !== exp_busy) begin
        errors++;
        $display("FAIL frame_a5 cycle %0d: got tx=%b busy=%b expected tx=%b busy=%b",
                 c, uart_tx, tx_busy, exp_tx, exp_busy);
      end
    end
    checks++;
    if (mon_q.size() != 1 || mon_q[0] !== 8'hA5) begin
      errors++;
      $display("FAIL frame_a5_decode: got %0d bytes expected 1 byte a5", mon_q.size());
    end
    repeat (3) @(posedge clk100); #1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    bit         done;
    bit         saw_busy;
    mon_q.delete();
    for (int i = 0; i < 5; i++) begin
      IO_port_ID      = 8'h01;
      IO_write_data   = 8'h11 + 8'(i);
      IO_write_strobe = 1'b1;
      @(posedge clk100); #1;
    end
    IO_write_strobe = 1'b0;
    io_read(8'h03, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("FAIL fifo_full_read: got %h expected ff", d);
    end
    io_write(8'h01, 8'h16);
    io_read(8'h04, d);
    checks++;
    if (d !== 8'h0A) begin
      errors++;
      $display("FAIL overflow_status: got %h expected 0a", d);
    end
    io_write(8'h04, 8'h08);
    io_read(8'h04, d);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("FAIL overflow_clear: got %h expected 02", d);
    end
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk100); #1;
      if (mon_q.size() >= 5 && tx_busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d frames expected 5", mon_q.size());
    end
    saw_busy = 1'b0;
    repeat (60) begin
      @(posedge clk100); #1;
      if (tx_busy !== 1'b0) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy || mon_q.size() != 5) begin
      errors++;
      $display("FAIL b2b_extra_frame: got %0d frames busy=%b expected 5 frames busy=0",
               mon_q.size(), saw_busy);
    end
    for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== 8'h11 + 8'(i)) begin
        errors++;
        $display("FAIL b2b_byte %0d: got %h expected %h", i, mon_q[i], 8'h11 + 8'(i));
      end
    end
  endtask

  task automatic test_rx;
    logic [7:0] d;
    rx_data = 8'h3C; rx_valid = 1'b1;
    @(posedge clk100); #1;
    rx_valid = 1'b0;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rx_ready_full: got %b expected 0", rx_ready);
    end
    io_read(8'h02, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("FAIL rx_present: got %h expected ff", d);
    end
    rx_data = 8'h77; rx_valid = 1'b1;
    @(posedge clk100); #1;
    rx_valid = 1'b0;
    io_read(8'h04, d);
    checks++;
    if (d !== 8'h05) begin
      errors++;
      $display("FAIL rx_status: got %h expected 05", d);
    end
    io_read(8'h01, d);
    checks++;
    if (d !== 8'h3C) begin
      errors++;
      $display("FAIL rx_data_read: got %h expected 3c", d);
    end
    io_read(8'h02, d);
    checks++;
    if (d !== 8'h00 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rx_cleared: got %h rdy=%b expected 00 rdy=1", d, rx_ready);
    end
    io_read(8'h01, d);
    checks++;
    if (d !== 8'h3C || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rx_stale_read: got %h rdy=%b expected 3c rdy=1", d, rx_ready);
    end
  endtask

  task automatic test_unmapped;
    logic [7:0] d;
    io_read(8'h7E, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("FAIL unmapped_read: got %h expected ff", d);
    end
    io_write(8'h02, 8'h08);
    @(posedge clk100); #1;
    io_read(8'h04, d);
    checks++;
    if (d !== 8'h04 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL write_port2: got status %h tx=%b expected 04 tx=1", d, uart_tx);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    bit         saw_activity;
    for (int i = 0; i < 3; i++) begin
      IO_port_ID      = 8'h01;
      IO_write_data   = 8'h00;
      IO_write_strobe = 1'b1;
      @(posedge clk100); #1;
    end
    IO_write_strobe = 1'b0;
    repeat (16) @(posedge clk100); #1;
    checks++;
    if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_pre: got tx=%b busy=%b expected 0 1", uart_tx, tx_busy);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL midframe_async: got tx=%b busy=%b rdy=%b expected 1 0 1",
               uart_tx, tx_busy, rx_ready);
    end
    IO_port_ID = 8'h04; IO_read_strobe = 1'b1; #1;
    d = IO_read_data;
    IO_read_strobe = 1'b0;
    checks++;
    if (d !== 8'h04) begin
      errors++;
      $display("FAIL midframe_reset_status: got %h expected 04", d);
    end
    @(posedge clk100); #1;
    reset = 1'b1;
    io_read(8'h04, d);
    checks++;
    if (d !== 8'h04) begin
      errors++;
      $display("FAIL midframe_post_status: got %h expected 04", d);
    end
    saw_activity = 1'b0;
    repeat (60) begin
      @(posedge clk100); #1;
      if (tx_busy !== 1'b0 || uart_tx !== 1'b1) saw_activity = 1'b1;
    end
    checks++;
    if (saw_activity) begin
      errors++;
      $display("FAIL midframe_no_frames: got activity expected idle line");
    end
  endtask

  initial begin
    reset           = 1'b0;
    IO_port_ID      = 8'h00;
    IO_write_data   = 8'h00;
    IO_write_strobe = 1'b0;
    IO_read_strobe  = 1'b0;
    rx_data         = 8'h00;
    rx_valid        = 1'b0;
    #16;
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_rx;
    test_unmapped;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
